axis_deadlock_monitor_gen: RTL and testbench
============================================

Name: axis_deadlock_monitor_gen

Overview:
Parametrised kernel-level deadlock monitor for HLS-generated kernels with an arbitrary number of AXI-Stream ports and sub-instances. It filters raw block indications through a configurable persistence threshold, drives a registered kernel_block flag, and captures destination/source snapshots of the AXIS block vector through a report FSM. Reports are handed to the testbench with a valid/ack handshake, up to MAX_REPORTS per reset. It sits beside the kernel instance in the simulation top, one monitor per kernel.

Parameters:
N_AXIS, 2, number of AXIS ports monitored (>=1)
N_INST, 3, number of sub-instance idle/block signals (>=1)
CONFIRM_CYCLES, 2, consecutive raw-block cycles required before kernel_block asserts (>=1)
MAX_REPORTS, 1, maximum reports issued per reset (>=1)
CNT_W, 16, width of the block-duration counter

Ports:
kernel_monitor_clock  in  1  single clock; all logic on rising edge
kernel_monitor_reset  in  1  synchronous, active-high reset
axis_block_sigs  in  N_AXIS  bit i = 1: AXIS port i blocked externally (no data / not ready)
inst_idle_sigs  in  N_INST  bit j = 1: instance j idle
inst_block_sigs  in  N_INST  bit j = 1: instance j blocked internally
report_ack  in  1  consumer accepts current report
kernel_block  out  1  confirmed kernel block
report_valid  out  1  snapshot report available
block_info_dst  out  N_AXIS  captured ~axis_block_sigs (ports unreachable by kernel)
block_info_src  out  N_AXIS  captured axis_block_sigs (ports causing block)
block_cycles  out  CNT_W  cycles kernel_block has been high in current/last event
report_count  out  $clog2(MAX_REPORTS+1)  reports accepted so far

Behaviour:
- Reset, sampled on a rising edge: all outputs 0; persist counter 0; FSM IDLE; armed = 1. Reset wins over every other event, including mid-report.
- raw_block (comb) = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs). An all-idle kernel is never blocked.
- Persist counter, saturating at CONFIRM_CYCLES:
  - +1 on each edge sampling raw_block = 1.
  - Cleared on any edge sampling raw_block = 0.
- kernel_block is registered: set on the CONFIRM_CYCLES-th consecutive edge with raw_block = 1; cleared on the first edge with raw_block = 0. With CONFIRM_CYCLES = 1 it trails raw_block by exactly one cycle.
- block_cycles:
  - Cleared on the edge kernel_block goes 0->1.
  - +1 on each edge while kernel_block = 1, saturating at all-ones.
  - Holds its value after kernel_block falls.
- armed: set on any edge with kernel_block = 0; cleared on report acceptance.
- FSM (one-hot IDLE, COLLECT_DST, COLLECT_SRC, DONE):
  - IDLE -> COLLECT_DST when kernel_block & armed & (report_count < MAX_REPORTS).
  - COLLECT_DST: block_info_dst <= ~axis_block_sigs; -> COLLECT_SRC.
  - COLLECT_SRC: block_info_src <= axis_block_sigs; -> DONE.
  - DONE: report_valid = 1 (registered, high in every DONE cycle). On report_ack: report_count +1, armed <= 0, -> IDLE. Without ack, hold; snapshots stay stable.
- report_ack outside DONE is ignored.
- If kernel_block falls during COLLECT_*, collection still completes with the live axis_block_sigs.
- One report per block event: re-entry requires kernel_block to fall and rise again.
- Once report_count = MAX_REPORTS, the FSM stays in IDLE. kernel_block and block_cycles keep operating.

Test Plan:
- Reset, then raw_block = 0 for 20 cycles -> all outputs 0, FSM stays IDLE.
- Defaults; axis_block_sigs = 2'b01, inst_idle = 3'b000 held -> kernel_block rises on the 2nd edge. report_valid rises 3 cycles after kernel_block (after DONE entry). dst = 2'b10, src = 2'b01.
- raw_block pulses 1,0,1,0 with CONFIRM_CYCLES = 2 -> kernel_block never asserts, report_valid stays 0.
- report_valid held 5 cycles without ack -> snapshots stable. Ack -> report_count = 1, report_valid = 0 next cycle. Block persists -> no second report. Block drops and re-rises with MAX_REPORTS = 1 -> no report, block_cycles restarts at 0.
- N_AXIS = 4, MAX_REPORTS = 2, two separate block events with src 4'b0100 then 4'b1001 -> two reports with matching src/dst, report_count = 2.
- Reset asserted during COLLECT_SRC -> next cycle FSM IDLE, all outputs 0. inst_idle = all ones with axis block -> kernel_block stays 0.

Source files
------------

// File: rtl/axis_deadlock_monitor_gen.sv
// axis_deadlock_monitor_gen
//   Kernel-level deadlock monitor for an HLS kernel. Raw block indications are
//   filtered through a persistence threshold to give a registered kernel_block.
//   A one-hot report FSM then captures dst/src snapshots of the AXIS block
//   vector and offers them to the consumer with a valid/ack handshake. At most
//   MAX_REPORTS reports are issued per reset.
// Ports:
//   kernel_monitor_clock  clock; all logic on the rising edge
//   kernel_monitor_reset  synchronous, active-high reset
//   axis_block_sigs       per-AXIS-port external block indication
//   inst_idle_sigs        per-instance idle indication
//   inst_block_sigs       per-instance internal block indication
//   report_ack            consumer accepts the current report (DONE only)
//   kernel_block          confirmed kernel block
//   report_valid          snapshot report available
//   block_info_dst        captured ~axis_block_sigs
//   block_info_src        captured axis_block_sigs
//   block_cycles          cycles kernel_block has been high in current/last event
//   report_count          reports accepted so far
module axis_deadlock_monitor_gen #(
  parameter int N_AXIS         = 2,
  parameter int N_INST         = 3,
  parameter int CONFIRM_CYCLES = 2,
  parameter int MAX_REPORTS    = 1,
  parameter int CNT_W          = 16
) (
  input  logic                               kernel_monitor_clock,
  input  logic                               kernel_monitor_reset,
  input  logic [N_AXIS-1:0]                  axis_block_sigs,
  input  logic [N_INST-1:0]                  inst_idle_sigs,
  input  logic [N_INST-1:0]                  inst_block_sigs,
  input  logic                               report_ack,
  output logic                               kernel_block,
  output logic                               report_valid,
  output logic [N_AXIS-1:0]                  block_info_dst,
  output logic [N_AXIS-1:0]                  block_info_src,
  output logic [CNT_W-1:0]                   block_cycles,
  output logic [$clog2(MAX_REPORTS+1)-1:0]   report_count
);

  localparam int PW = $clog2(CONFIRM_CYCLES+1);
  localparam int RW = $clog2(MAX_REPORTS+1);
  localparam logic [PW:0]   C_VAL   = (PW+1)'(CONFIRM_CYCLES);
  localparam logic [RW-1:0] MAX_VAL = RW'(MAX_REPORTS);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_DST  = 4'b0010,
    S_SRC  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [PW-1:0]       r_persist;
  logic                r_kb;
  logic                r_armed;
  logic                r_rv;
  logic [N_AXIS-1:0]   r_dst, r_src;
  logic [CNT_W-1:0]    r_bc;
  logic [RW-1:0]       r_cnt;

  logic                w_raw;
  logic [PW:0]         w_persist_inc;
  logic                w_persist_sat;
  logic                w_kb_nxt;
  logic                w_accept;

  // An all-idle kernel is never considered blocked.
  assign w_raw         = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs);
  // One extra bit so the increment cannot wrap before the threshold compare.
  assign w_persist_inc = {1'b0, r_persist} + 1'b1;
  assign w_persist_sat = (w_persist_inc >= C_VAL);
  assign w_kb_nxt      = w_raw & w_persist_sat;

  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) r_state <= S_IDLE;
    else                      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (r_kb && r_armed && (r_cnt < MAX_VAL)) w_state_nxt = S_DST;
      S_DST:  w_state_nxt = S_SRC;
      S_SRC:  w_state_nxt = S_DONE;
      S_DONE: if (report_ack) begin
        w_accept    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) begin
      r_persist <= '0;
      r_kb      <= 1'b0;
      r_armed   <= 1'b1;
      r_rv      <= 1'b0;
      r_dst     <= '0;
      r_src     <= '0;
      r_bc      <= '0;
      r_cnt     <= '0;
    end else begin
      if (!w_raw)             r_persist <= '0;
      else if (w_persist_sat) r_persist <= C_VAL[PW-1:0];
      else                    r_persist <= w_persist_inc[PW-1:0];

      r_kb <= w_kb_nxt;

      // Restart on the rising edge of kernel_block; hold once it falls.
      if (w_kb_nxt && !r_kb)        r_bc <= '0;
      else if (r_kb && (r_bc != '1)) r_bc <= r_bc + 1'b1;

      // Acceptance disarms; any cycle without a block re-arms.
      if (w_accept)   r_armed <= 1'b0;
      else if (!r_kb) r_armed <= 1'b1;

      // Snapshots use live inputs even if kernel_block has already dropped.
      if (r_state == S_DST) r_dst <= ~axis_block_sigs;
      if (r_state == S_SRC) r_src <= axis_block_sigs;

      r_rv <= (w_state_nxt == S_DONE);

      if (w_accept) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign kernel_block   = r_kb;
  assign report_valid   = r_rv;
  assign block_info_dst = r_dst;
  assign block_info_src = r_src;
  assign block_cycles   = r_bc;
  assign report_count   = r_cnt;

endmodule

// File: tb/tb_axis_deadlock_monitor_gen.sv
// Directed testbench for axis_deadlock_monitor_gen. Instance A uses default
// parameters; instance B uses N_AXIS=4, MAX_REPORTS=2, CONFIRM_CYCLES=1.
module tb_axis_deadlock_monitor_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A (defaults)
  logic [1:0]  a_axis = '0;
  logic [2:0]  a_idle = '0, a_iblk = '0;
  logic        a_ack  = 1'b0;
  logic        a_kb, a_rv;
  logic [1:0]  a_dst, a_src;
  logic [15:0] a_bc;
  logic [0:0]  a_cnt;

  // Instance B
  logic [3:0]  b_axis = '0;
  logic [2:0]  b_idle = '0, b_iblk = '0;
  logic        b_ack  = 1'b0;
  logic        b_kb, b_rv;
  logic [3:0]  b_dst, b_src;
  logic [15:0] b_bc;
  logic [1:0]  b_cnt;

  axis_deadlock_monitor_gen u_a (
    .kernel_monitor_clock(clk), .kernel_monitor_reset(rst),
    .axis_block_sigs(a_axis), .inst_idle_sigs(a_idle), .inst_block_sigs(a_iblk),
    .report_ack(a_ack), .kernel_block(a_kb), .report_valid(a_rv),
    .block_info_dst(a_dst), .block_info_src(a_src),
    .block_cycles(a_bc), .report_count(a_cnt));

  axis_deadlock_monitor_gen #(.N_AXIS(4), .N_INST(3), .CONFIRM_CYCLES(1),
                              .MAX_REPORTS(2), .CNT_W(16)) u_b (
    .kernel_monitor_clock(clk), .kernel_monitor_reset(rst),
    .axis_block_sigs(b_axis), .inst_idle_sigs(b_idle), .inst_block_sigs(b_iblk),
    .report_ack(b_ack), .kernel_block(b_kb), .report_valid(b_rv),
    .block_info_dst(b_dst), .block_info_src(b_src),
    .block_cycles(b_bc), .report_count(b_cnt));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_kb"},  {31'd0, a_kb},  32'd0);
    chk({tag, "_rv"},  {31'd0, a_rv},  32'd0);
    chk({tag, "_dst"}, {30'd0, a_dst}, 32'd0);
    chk({tag, "_src"}, {30'd0, a_src}, 32'd0);
    chk({tag, "_bc"},  {16'd0, a_bc},  32'd0);
    chk({tag, "_cnt"}, {31'd0, a_cnt}, 32'd0);
  endtask

  initial begin
    // ---- reset state ----
    tick(2);
    rst = 1'b0;
    chk_a_zero("rst");
    chk("rst_b_rv",  {31'd0, b_rv},  32'd0);
    chk("rst_b_cnt", {30'd0, b_cnt}, 32'd0);

    // ---- quiet for 20 cycles, with a stray ack that must be ignored ----
    a_ack = 1'b1;
    tick(1);
    a_ack = 1'b0;
    tick(19);
    chk_a_zero("quiet");

    // ---- raw_block pulses 1,0,1,0: threshold never reached ----
    for (int i = 0; i < 2; i++) begin
      a_axis = 2'b01; tick(1);
      chk("pulse_hi_kb", {31'd0, a_kb}, 32'd0);
      a_axis = 2'b00; tick(1);
      chk("pulse_lo_kb", {31'd0, a_kb}, 32'd0);
      chk("pulse_rv",    {31'd0, a_rv}, 32'd0);
    end

    // ---- main report flow ----
    a_axis = 2'b01;
    tick(1);
    chk("m_e1_kb", {31'd0, a_kb}, 32'd0);
    tick(1);
    chk("m_e2_kb", {31'd0, a_kb}, 32'd1);
    chk("m_e2_bc", {16'd0, a_bc}, 32'd0);
    tick(1);
    chk("m_e3_rv", {31'd0, a_rv}, 32'd0);
    chk("m_e3_bc", {16'd0, a_bc}, 32'd1);
    tick(1);
    chk("m_e4_rv", {31'd0, a_rv}, 32'd0);
    tick(1);
    chk("m_e5_rv",  {31'd0, a_rv},  32'd1);
    chk("m_e5_dst", {30'd0, a_dst}, 32'h2);
    chk("m_e5_src", {30'd0, a_src}, 32'h1);
    chk("m_e5_bc",  {16'd0, a_bc},  32'd3);

    // hold without ack: everything stable; inputs change must not disturb
    a_axis = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("hold_rv",  {31'd0, a_rv},  32'd1);
      chk("hold_dst", {30'd0, a_dst}, 32'h2);
      chk("hold_src", {30'd0, a_src}, 32'h1);
    end
    a_axis = 2'b01;
    a_ack = 1'b1;
    tick(1);
    a_ack = 1'b0;
    chk("ack_cnt", {31'd0, a_cnt}, 32'd1);
    chk("ack_rv",  {31'd0, a_rv},  32'd0);

    // block persists: no second report
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("persist_rv", {31'd0, a_rv}, 32'd0);
    end
    chk("persist_bc", {16'd0, a_bc}, 32'd15);

    // drop: bc counts the final high cycle and then holds
    a_axis = 2'b00;
    tick(1);
    chk("drop_kb", {31'd0, a_kb}, 32'd0);
    chk("drop_bc", {16'd0, a_bc}, 32'd16);
    tick(2);
    chk("drop_hold_bc", {16'd0, a_bc}, 32'd16);

    // re-rise at MAX_REPORTS: no report, bc restarts
    a_axis = 2'b01;
    tick(2);
    chk("rerise_kb", {31'd0, a_kb}, 32'd1);
    chk("rerise_bc", {16'd0, a_bc}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("rerise_rv", {31'd0, a_rv}, 32'd0);
    end
    chk("rerise_cnt", {31'd0, a_cnt}, 32'd1);
    a_axis = 2'b00;

    // ---- instance B: two events, CONFIRM_CYCLES = 1 ----
    b_axis = 4'b0100;
    tick(1);
    chk("b1_kb", {31'd0, b_kb}, 32'd1);
    tick(3);
    chk("b1_rv",  {31'd0, b_rv},  32'd1);
    chk("b1_dst", {28'd0, b_dst}, 32'hB);
    chk("b1_src", {28'd0, b_src}, 32'h4);
    b_ack = 1'b1;
    tick(1);
    b_ack = 1'b0;
    chk("b1_cnt", {30'd0, b_cnt}, 32'd1);
    chk("b1_rv0", {31'd0, b_rv},  32'd0);
    b_axis = 4'b0000;
    tick(1);
    chk("b_drop_kb", {31'd0, b_kb}, 32'd0);
    tick(1);
    b_axis = 4'b1001;
    tick(4);
    chk("b2_rv",  {31'd0, b_rv},  32'd1);
    chk("b2_dst", {28'd0, b_dst}, 32'h6);
    chk("b2_src", {28'd0, b_src}, 32'h9);
    b_ack = 1'b1;
    tick(1);
    b_ack = 1'b0;
    chk("b2_cnt", {30'd0, b_cnt}, 32'd2);
    b_axis = 4'b0000;
    tick(2);
    b_axis = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("b3_rv", {31'd0, b_rv}, 32'd0);
    end
    chk("b3_cnt", {30'd0, b_cnt}, 32'd2);
    b_axis = 4'b0000;

    // ---- reset during COLLECT_SRC ----
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    a_axis = 2'b01;
    tick(4);
    chk("csrc_dst", {30'd0, a_dst}, 32'h2);
    chk("csrc_rv",  {31'd0, a_rv},  32'd0);
    rst = 1'b1;
    tick(1);
    chk_a_zero("midrst");
    a_axis = 2'b00;
    rst = 1'b0;
    tick(3);
    chk("post_rst_rv", {31'd0, a_rv}, 32'd0);

    // ---- all-idle kernel is never blocked ----
    a_idle = 3'b111;
    a_iblk = 3'b111;
    a_axis = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("idle_kb", {31'd0, a_kb}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
